spr_fifo_ctrl: RTL and testbench

SPR_FIFO_CTRL -- requirements
Module: spr_fifo_ctrl

---
 rtl/spr_fifo_ctrl_pkg.sv | 27 ++
 rtl/spr_fifo_ctrl.sv | 108 ++++++++++
 tb/tb_spr_fifo_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/spr_fifo_ctrl_pkg.sv
// Shared constants and types for the single-port-RAM FIFO controller.
// Depth, widths and the per-cycle RAM activity encoding live here.
package spr_fifo_ctrl_pkg;

  localparam int RAM_DEPTH = 16;
  localparam int DATA_W    = 4;
  localparam int CNT_W     = 5;
  localparam int AW        = 4;

  localparam logic [CNT_W-1:0] MEM_EMPTY = 5'd0;
  localparam logic [CNT_W-1:0] MEM_FULL  = 5'd16;
  localparam logic [CNT_W-1:0] CNT_ONE   = 5'd1;
  localparam logic [AW-1:0]    PTR_ONE   = 4'd1;

  // What the shared RAM port is doing this cycle
  typedef enum logic [1:0] {
    CYC_IDLE = 2'd0,
    CYC_RD   = 2'd1,
    CYC_WR   = 2'd2,
    CYC_BYP  = 2'd3
  } cyc_e;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return ptr + PTR_ONE;
  endfunction

endpackage

// File: rtl/spr_fifo_ctrl.sv
// FIFO controller over an external 16x4 single-port LUT RAM with a one-entry
// output stage; holds up to 17 nibbles, reads win the shared port over writes.
module spr_fifo_ctrl
  import spr_fifo_ctrl_pkg::*;
#(
  parameter logic [DATA_W-1:0] POP_DATA_RST = 4'h0
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              PUSH_VALID,
  input  logic [DATA_W-1:0] PUSH_DATA,
  output logic              PUSH_READY,
  output logic              POP_VALID,
  output logic [DATA_W-1:0] POP_DATA,
  input  logic              POP_READY,
  output logic [CNT_W-1:0]  COUNT,
  output logic [AW-1:0]     RAM_AD,
  output logic [DATA_W-1:0] RAM_DI,
  output logic              RAM_WRE,
  input  logic [DATA_W-1:0] RAM_DO
);

  logic [AW-1:0]     wptr_r;
  logic [AW-1:0]     rptr_r;
  logic [CNT_W-1:0]  mem_cnt_r;
  logic              stage_v_r;
  logic [DATA_W-1:0] stage_d_r;

  logic              pop_fire_s;
  logic              push_fire_s;
  logic              stage_free_s;
  logic              rd_cyc_s;
  logic              push_ready_s;
  cyc_e              cyc_s;

  // Handshake qualifiers and classification of this cycle's RAM activity
  always_comb begin
    pop_fire_s   = stage_v_r & POP_READY;
    stage_free_s = ~stage_v_r | pop_fire_s;
    rd_cyc_s     = stage_free_s & (mem_cnt_r != MEM_EMPTY);
    push_ready_s = ~RST & ~rd_cyc_s & (mem_cnt_r != MEM_FULL);
    push_fire_s  = PUSH_VALID & push_ready_s;
    if (rd_cyc_s) begin
      cyc_s = CYC_RD;
    end else if (push_fire_s & stage_free_s & (mem_cnt_r == MEM_EMPTY)) begin
      cyc_s = CYC_BYP;
    end else if (push_fire_s) begin
      cyc_s = CYC_WR;
    end else begin
      cyc_s = CYC_IDLE;
    end
  end

  // Shared RAM port: write pointer only on a write, read pointer otherwise
  always_comb begin
    RAM_DI  = PUSH_DATA;
    RAM_AD  = rptr_r;
    RAM_WRE = 1'b0;
    case (cyc_s)
      CYC_WR: begin
        RAM_AD  = wptr_r;
        RAM_WRE = ~RST;
      end
      CYC_RD:   RAM_AD = rptr_r;
      CYC_BYP:  RAM_AD = rptr_r;
      CYC_IDLE: RAM_AD = rptr_r;
      default:  RAM_AD = rptr_r;
    endcase
  end

  // Pointer, occupancy and output-stage state
  always_ff @(posedge CK) begin
    if (RST) begin
      wptr_r    <= 4'd0;
      rptr_r    <= 4'd0;
      mem_cnt_r <= 5'd0;
      stage_v_r <= 1'b0;
      stage_d_r <= POP_DATA_RST;
    end else begin
      case (cyc_s)
        CYC_RD: begin
          rptr_r    <= ptr_inc(rptr_r);
          mem_cnt_r <= mem_cnt_r - CNT_ONE;
          stage_d_r <= RAM_DO;
          stage_v_r <= 1'b1;
        end
        CYC_BYP: begin
          stage_d_r <= PUSH_DATA;
          stage_v_r <= 1'b1;
        end
        CYC_WR: begin
          wptr_r    <= ptr_inc(wptr_r);
          mem_cnt_r <= mem_cnt_r + CNT_ONE;
          stage_v_r <= stage_v_r & ~pop_fire_s;
        end
        default: begin
          stage_v_r <= stage_v_r & ~pop_fire_s;
        end
      endcase
    end
  end

  assign PUSH_READY = push_ready_s;
  assign POP_VALID  = stage_v_r;
  assign POP_DATA   = stage_d_r;
  assign COUNT      = mem_cnt_r + {4'd0, stage_v_r};

endmodule

// File: tb/tb_spr_fifo_ctrl.sv
// Directed bench for spr_fifo_ctrl with a behavioural 16x4 async-read RAM
// and a queue scoreboard for the randomised ordering run.
`timescale 1ns/1ps
module tb_spr_fifo_ctrl;

  localparam logic [3:0] RST_VAL = 4'h6;

  logic       CK = 1'b0;
  logic       RST;
  logic       PUSH_VALID;
  logic [3:0] PUSH_DATA;
  logic       PUSH_READY;
  logic       POP_VALID;
  logic [3:0] POP_DATA;
  logic       POP_READY;
  logic [4:0] COUNT;
  logic [3:0] RAM_AD;
  logic [3:0] RAM_DI;
  logic       RAM_WRE;
  logic [3:0] RAM_DO;

  logic [3:0] ram [16];

  int n_checks = 0;
  int n_pass   = 0;

  spr_fifo_ctrl #(.POP_DATA_RST(RST_VAL)) dut (
    .CK(CK), .RST(RST),
    .PUSH_VALID(PUSH_VALID), .PUSH_DATA(PUSH_DATA), .PUSH_READY(PUSH_READY),
    .POP_VALID(POP_VALID), .POP_DATA(POP_DATA), .POP_READY(POP_READY),
    .COUNT(COUNT), .RAM_AD(RAM_AD), .RAM_DI(RAM_DI), .RAM_WRE(RAM_WRE),
    .RAM_DO(RAM_DO)
  );

  always #5 CK = ~CK;

  // Behavioural single-port LUT RAM: synchronous write, asynchronous read
  always @(posedge CK) begin
    if (RAM_WRE) ram[RAM_AD] <= RAM_DI;
  end
  assign RAM_DO = ram[RAM_AD];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; PUSH_VALID = 1'b0; PUSH_DATA = 4'h0; POP_READY = 1'b0;
    tick(); tick();
    RST = 1'b0;
  endtask

  // Push one word per cycle with the downstream stalled
  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      PUSH_VALID = 1'b1;
      PUSH_DATA  = 4'((base + i) % 16);
      tick();
    end
    PUSH_VALID = 1'b0;
  endtask

  logic [3:0] exp_seq [17];
  logic [3:0] sb [$];
  logic [3:0] exp_w;
  int pushed, popped, cyc;

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 4'h0;
    for (int i = 0; i < 16; i++) exp_seq[i] = 4'(i);
    exp_seq[16] = 4'h1;

    // Reset state
    RST = 1'b1; PUSH_VALID = 1'b1; PUSH_DATA = 4'h3; POP_READY = 1'b0;
    tick(); #1;
    check("rst_push_ready", PUSH_READY, 1'b0);
    check("rst_ram_wre", RAM_WRE, 1'b0);
    check("rst_count", COUNT, 5'd0);
    check("rst_pop_valid", POP_VALID, 1'b0);
    check("rst_pop_data", POP_DATA, RST_VAL);
    do_reset();

    // Bypass push into empty FIFO
    PUSH_VALID = 1'b1; PUSH_DATA = 4'hA; #1;
    check("byp_push_ready", PUSH_READY, 1'b1);
    check("byp_ram_wre", RAM_WRE, 1'b0);
    tick();
    PUSH_VALID = 1'b0; #1;
    check("byp_pop_valid", POP_VALID, 1'b1);
    check("byp_pop_data", POP_DATA, 4'hA);
    check("byp_count", COUNT, 5'd1);
    check("byp_ram_wre_after", RAM_WRE, 1'b0);

    // Fill to 17 entries: 0..F then 1
    do_reset();
    for (int i = 0; i < 17; i++) begin
      PUSH_VALID = 1'b1; PUSH_DATA = exp_seq[i]; #1;
      check("fill_ready", PUSH_READY, 1'b1);
      tick();
    end
    PUSH_VALID = 1'b0; #1;
    check("full_count", COUNT, 5'd17);
    check("full_push_ready", PUSH_READY, 1'b0);
    PUSH_VALID = 1'b1; PUSH_DATA = 4'h5; #1;
    check("full_no_wre", RAM_WRE, 1'b0);
    tick();
    PUSH_VALID = 1'b0; #1;
    check("full_ignored_count", COUNT, 5'd17);
    check("full_head", POP_DATA, 4'h0);

    // Drain from full with continuous ready
    POP_READY = 1'b1;
    for (int i = 0; i < 17; i++) begin
      #1;
      check("drain_valid", POP_VALID, 1'b1);
      check("drain_data", POP_DATA, exp_seq[i]);
      tick();
    end
    #1;
    check("drain_empty_valid", POP_VALID, 1'b0);
    check("drain_empty_count", COUNT, 5'd0);
    check("drain_empty_wre", RAM_WRE, 1'b0);

    // Read wins over a same-cycle push: stage_v=1, mem_cnt=3
    do_reset();
    push_n(4, 8);
    #1;
    check("prio_setup_count", COUNT, 5'd4);
    PUSH_VALID = 1'b1; PUSH_DATA = 4'hC; POP_READY = 1'b1; #1;
    check("prio_push_ready", PUSH_READY, 1'b0);
    check("prio_ram_wre", RAM_WRE, 1'b0);
    check("prio_ram_ad", RAM_AD, 4'd0);
    tick();
    PUSH_VALID = 1'b0; POP_READY = 1'b0; #1;
    check("prio_pop_data", POP_DATA, 4'h9);
    check("prio_count", COUNT, 5'd3);

    // Mid-stream reset discards entries; next push bypasses
    do_reset();
    push_n(9, 2);
    #1;
    check("mrst_setup_count", COUNT, 5'd9);
    RST = 1'b1; PUSH_VALID = 1'b1; PUSH_DATA = 4'hE; POP_READY = 1'b1;
    tick();
    RST = 1'b0; PUSH_VALID = 1'b0; POP_READY = 1'b0; #1;
    check("mrst_count", COUNT, 5'd0);
    check("mrst_pop_valid", POP_VALID, 1'b0);
    check("mrst_pop_data", POP_DATA, RST_VAL);
    PUSH_VALID = 1'b1; PUSH_DATA = 4'h3; #1;
    check("mrst_byp_wre", RAM_WRE, 1'b0);
    tick();
    PUSH_VALID = 1'b0; #1;
    check("mrst_byp_data", POP_DATA, 4'h3);
    check("mrst_byp_count", COUNT, 5'd1);

    // Random valid/ready, 40 words, order checked against a queue
    do_reset();
    sb.delete();
    pushed = 0; popped = 0; cyc = 0;
    while (popped < 40 && cyc < 3000) begin
      PUSH_VALID = (pushed < 40) && ($urandom_range(0, 3) != 0);
      PUSH_DATA  = 4'($urandom_range(0, 15));
      POP_READY  = (cyc > 20) && ($urandom_range(0, 2) != 0);
      #1;
      if (PUSH_VALID && PUSH_READY) begin
        sb.push_back(PUSH_DATA);
        pushed++;
      end
      if (POP_VALID && POP_READY) begin
        if (sb.size() == 0) begin
          check("rand_underflow", 32'd1, 32'd0);
        end else begin
          exp_w = sb.pop_front();
          check("rand_order", POP_DATA, exp_w);
        end
        popped++;
      end
      tick();
      cyc++;
    end
    PUSH_VALID = 1'b0; POP_READY = 1'b0; #1;
    check("rand_done", popped, 32'd40);
    check("rand_final_count", COUNT, 5'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
